alu_compare: RTL and testbench
==============================

ALU_COMPARE -- requirements
Module: alu_compare

Interface
REQ-001 Parameter: none; data width fixed at 32 bits.
REQ-002 CLK  input  1  clock; rising edge updates HI/LO registers.
REQ-003 RESET  input  1  reset, asynchronous, active-low.
REQ-004 op_a  input  32  ALU operand 1 (rs, or PC for branch-target add).
REQ-005 op_b  input  32  ALU operand 2 (rt, immediate, or imm<<2).
REQ-006 alu_ctrl  input  6  operation select (encoding in REQ-011).
REQ-007 shamt  input  5  shift amount for immediate shifts (instr[10:6]).
REQ-008 hi_in, lo_in  input  32 each  externally supplied HI/LO values for MFHI/MFLO.
REQ-009 result  output  32  combinational ALU result; hi_out, lo_out  output  32 each  registered HI/LO.
REQ-010 cmp_kill  input  1  forces taken=0; cmp_a, cmp_b  input  32  branch operands (rs, rt); instr  input  32  branch instruction; taken  output  1  combinational branch decision.

Function
REQ-011 alu_ctrl encoding (hex): 00 SLL, 02 SRL, 03 SRA, 04 SLLV, 06 SRLV, 07 SRAV, 0F LUI, 10 MFHI, 12 MFLO, 18 MULT, 19 MULTU, 1A DIV, 1B DIVU, 20 ADD, 21 ADDU, 22 SUB, 23 SUBU, 24 AND, 25 OR, 26 XOR, 27 NOR, 2A SLT, 2B SLTU.
REQ-012 ADD/ADDU = op_a+op_b, SUB/SUBU = op_a-op_b, modulo 2^32; no overflow trap or flag.
REQ-013 AND/OR/XOR/NOR bitwise on op_a, op_b.
REQ-014 SLT = 1 if signed op_a < signed op_b else 0; SLTU unsigned; upper 31 bits zero.
REQ-015 SLL/SRL/SRA shift op_b by shamt; SLLV/SRLV/SRAV shift op_b by op_a[4:0]; SRA/SRAV sign-fill.
REQ-016 LUI result = {op_b[15:0], 16'h0000}.
REQ-017 MFHI result = hi_in; MFLO result = lo_in.
REQ-018 MULT/MULTU/DIV/DIVU: result = 0; on next rising CLK hi_out/lo_out load the new values.
REQ-019 MULT signed, MULTU unsigned 64-bit product: hi_out = product[63:32], lo_out = product[31:0].
REQ-020 DIV signed, DIVU unsigned: lo_out = quotient, hi_out = remainder; signed quotient truncates toward zero, remainder takes sign of dividend.
REQ-021 Divide by zero: lo_out = 32'hFFFFFFFF, hi_out = op_a; no trap.
REQ-022 Signed DIV 0x80000000 / 0xFFFFFFFF: lo_out = 0x80000000, hi_out = 0.
REQ-023 hi_out/lo_out hold value for any alu_ctrl not in 18-1B.
REQ-024 Undefined alu_ctrl codes: result = 0, no state change.
REQ-025 Branch decision, opcode = instr[31:26]: 04 BEQ cmp_a==cmp_b; 05 BNE cmp_a!=cmp_b; 06 BLEZ signed cmp_a<=0; 07 BGTZ signed cmp_a>0; 01 REGIMM with instr[20:16]=00 BLTZ cmp_a<0, 01 BGEZ cmp_a>=0.
REQ-026 taken = 0 for all other opcodes/rt codes, and whenever cmp_kill=1.
REQ-027 result and taken are purely combinational; zero latency; no internal state besides HI/LO.

Reset
REQ-028 RESET low asynchronously clears hi_out and lo_out to 0; combinational outputs unaffected.
REQ-029 Reset asserted in the same cycle as MULT/DIV: reset wins, registers stay 0.

Structure
REQ-030 alu_ctrl codes and branch opcode/rt constants SHALL live in a shared package (alu_pkg), reused by decode.
REQ-031 Branch comparator SHALL be a sub-module branch_compare (cmp_kill, cmp_a, cmp_b, instr, taken); ALU logic and HI/LO registers in the top.

Verification
REQ-032 op_a=0x7FFFFFFF, op_b=1, ctrl 20 -> result 0x80000000; ctrl 2A with op_a=0xFFFFFFFF, op_b=1 -> 1; ctrl 2B -> 0.
REQ-033 op_b=0x80000000, shamt=4: ctrl 03 -> 0xF8000000, ctrl 02 -> 0x08000000; ctrl 06 with op_a=0x24 -> 0x08000000.
REQ-034 op_a=-3 (0xFFFFFFFD), op_b=7, ctrl 18, one CLK -> hi_out 0xFFFFFFFF, lo_out 0xFFFFFFEB; ctrl 1A op_a=-7, op_b=2 -> lo_out 0xFFFFFFFD, hi_out 0xFFFFFFFF.
REQ-035 ctrl 1B op_b=0, op_a=5 -> lo_out 0xFFFFFFFF, hi_out 5; then RESET low mid-cycle -> both 0 immediately.
REQ-036 instr opcode 04, cmp_a=cmp_b=5 -> taken 1; same with cmp_kill=1 -> 0; opcode 01 rt=01, cmp_a=0 -> 1; opcode 07, cmp_a=0 -> 0.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU operation codes and branch decode constants
package alu_pkg;

    typedef enum logic [5:0] {
        ALU_SLL   = 6'h00,
        ALU_SRL   = 6'h02,
        ALU_SRA   = 6'h03,
        ALU_SLLV  = 6'h04,
        ALU_SRLV  = 6'h06,
        ALU_SRAV  = 6'h07,
        ALU_LUI   = 6'h0F,
        ALU_MFHI  = 6'h10,
        ALU_MFLO  = 6'h12,
        ALU_MULT  = 6'h18,
        ALU_MULTU = 6'h19,
        ALU_DIV   = 6'h1A,
        ALU_DIVU  = 6'h1B,
        ALU_ADD   = 6'h20,
        ALU_ADDU  = 6'h21,
        ALU_SUB   = 6'h22,
        ALU_SUBU  = 6'h23,
        ALU_AND   = 6'h24,
        ALU_OR    = 6'h25,
        ALU_XOR   = 6'h26,
        ALU_NOR   = 6'h27,
        ALU_SLT   = 6'h2A,
        ALU_SLTU  = 6'h2B
    } alu_op_e;

    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;

    localparam logic [4:0] RT_BLTZ = 5'h00;
    localparam logic [4:0] RT_BGEZ = 5'h01;

    // Multiply/divide codes occupy 0x18..0x1B, the only ops that write HI/LO.
    function automatic logic is_muldiv(input logic [5:0] ctrl);
        return ctrl[5:2] == 4'b0110;
    endfunction

endpackage

// File: rtl/branch_compare.sv
// rtl/branch_compare.sv - combinational branch-taken decision
module branch_compare
    import alu_pkg::*;
(
    input  logic        cmp_kill,
    input  logic [31:0] cmp_a,
    input  logic [31:0] cmp_b,
    input  logic [31:0] instr,
    output logic        taken
);

    logic [5:0] opcode;
    logic [4:0] rt;
    logic       a_zero;
    logic       a_neg;
    logic       taken_raw;
    logic       unused_instr;

    assign opcode       = instr[31:26];
    assign rt           = instr[20:16];
    assign a_zero       = (cmp_a == 32'h0);
    assign a_neg        = cmp_a[31];
    assign unused_instr = ^{instr[25:21], instr[15:0]};

    always_comb begin
        taken_raw = 1'b0;
        case (opcode)
            OP_BEQ:    taken_raw = (cmp_a == cmp_b);
            OP_BNE:    taken_raw = (cmp_a != cmp_b);
            OP_BLEZ:   taken_raw = a_neg | a_zero;
            OP_BGTZ:   taken_raw = ~a_neg & ~a_zero;
            OP_REGIMM: begin
                if (rt == RT_BLTZ)      taken_raw = a_neg;
                else if (rt == RT_BGEZ) taken_raw = ~a_neg;
                else                    taken_raw = 1'b0;
            end
            default:   taken_raw = 1'b0;
        endcase
    end

    assign taken = taken_raw & ~cmp_kill;

endmodule

// File: rtl/alu_compare.sv
// rtl/alu_compare.sv - 32-bit ALU with HI/LO multiply/divide registers and branch comparator
module alu_compare
    import alu_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [5:0]  alu_ctrl,
    input  logic [4:0]  shamt,
    input  logic [31:0] hi_in,
    input  logic [31:0] lo_in,
    output logic [31:0] result,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    input  logic        cmp_kill,
    input  logic [31:0] cmp_a,
    input  logic [31:0] cmp_b,
    input  logic [31:0] instr,
    output logic        taken
);

    logic [31:0] hi_q, lo_q, hi_d, lo_d;
    logic [31:0] result_d;
    logic [63:0] prod_s, prod_u;
    logic [31:0] abs_a, abs_b, mag_q, mag_r;
    logic [31:0] divu_q, divu_r;
    logic        div_zero;

    assign prod_s = {{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b};
    assign prod_u = {32'h0, op_a} * {32'h0, op_b};

    // Signed divide on magnitudes so truncation toward zero and INT_MIN/-1 fall out naturally.
    assign div_zero = (op_b == 32'h0);
    assign abs_a    = op_a[31] ? -op_a : op_a;
    assign abs_b    = op_b[31] ? -op_b : op_b;
    assign mag_q    = div_zero ? 32'h0 : abs_a / abs_b;
    assign mag_r    = div_zero ? 32'h0 : abs_a % abs_b;
    assign divu_q   = div_zero ? 32'h0 : op_a / op_b;
    assign divu_r   = div_zero ? 32'h0 : op_a % op_b;

    always_comb begin
        result_d = 32'h0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (alu_ctrl)
            ALU_SLL:   result_d = op_b << shamt;
            ALU_SRL:   result_d = op_b >> shamt;
            ALU_SRA:   result_d = $signed(op_b) >>> shamt;
            ALU_SLLV:  result_d = op_b << op_a[4:0];
            ALU_SRLV:  result_d = op_b >> op_a[4:0];
            ALU_SRAV:  result_d = $signed(op_b) >>> op_a[4:0];
            ALU_LUI:   result_d = {op_b[15:0], 16'h0000};
            ALU_MFHI:  result_d = hi_in;
            ALU_MFLO:  result_d = lo_in;
            ALU_MULT:  {hi_d, lo_d} = prod_s;
            ALU_MULTU: {hi_d, lo_d} = prod_u;
            ALU_DIV: begin
                if (div_zero) begin
                    lo_d = 32'hFFFF_FFFF;
                    hi_d = op_a;
                end else begin
                    lo_d = (op_a[31] ^ op_b[31]) ? -mag_q : mag_q;
                    hi_d = op_a[31] ? -mag_r : mag_r;
                end
            end
            ALU_DIVU: begin
                lo_d = div_zero ? 32'hFFFF_FFFF : divu_q;
                hi_d = div_zero ? op_a : divu_r;
            end
            ALU_ADD, ALU_ADDU: result_d = op_a + op_b;
            ALU_SUB, ALU_SUBU: result_d = op_a - op_b;
            ALU_AND:   result_d = op_a & op_b;
            ALU_OR:    result_d = op_a | op_b;
            ALU_XOR:   result_d = op_a ^ op_b;
            ALU_NOR:   result_d = ~(op_a | op_b);
            ALU_SLT:   result_d = {31'h0, $signed(op_a) < $signed(op_b)};
            ALU_SLTU:  result_d = {31'h0, op_a < op_b};
            default:   result_d = 32'h0;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            hi_q <= 32'h0;
            lo_q <= 32'h0;
        end else if (is_muldiv(alu_ctrl)) begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign result = result_d;
    assign hi_out = hi_q;
    assign lo_out = lo_q;

    branch_compare u_branch_compare (
        .cmp_kill (cmp_kill),
        .cmp_a    (cmp_a),
        .cmp_b    (cmp_b),
        .instr    (instr),
        .taken    (taken)
    );

endmodule

// File: tb/tb_alu_compare.sv
// tb/tb_alu_compare.sv - directed self-checking bench for alu_compare
module tb_alu_compare;

    logic        CLK;
    logic        RESET;
    logic [31:0] op_a, op_b, hi_in, lo_in;
    logic [5:0]  alu_ctrl;
    logic [4:0]  shamt;
    logic [31:0] result, hi_out, lo_out;
    logic        cmp_kill;
    logic [31:0] cmp_a, cmp_b, instr;
    logic        taken;

    int n_checks = 0;
    int n_fail   = 0;

    alu_compare dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .op_a     (op_a),
        .op_b     (op_b),
        .alu_ctrl (alu_ctrl),
        .shamt    (shamt),
        .hi_in    (hi_in),
        .lo_in    (lo_in),
        .result   (result),
        .hi_out   (hi_out),
        .lo_out   (lo_out),
        .cmp_kill (cmp_kill),
        .cmp_a    (cmp_a),
        .cmp_b    (cmp_b),
        .instr    (instr),
        .taken    (taken)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic alu_vec(input string tag, input logic [5:0] ctrl, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] sh, input logic [31:0] exp);
        alu_ctrl = ctrl;
        op_a     = a;
        op_b     = b;
        shamt    = sh;
        #1;
        check(tag, result, exp);
    endtask

    task automatic muldiv_vec(input string tag, input logic [5:0] ctrl, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        @(negedge CLK);
        alu_ctrl = ctrl;
        op_a     = a;
        op_b     = b;
        #1;
        check({tag, "_res"}, result, 32'h0);
        @(posedge CLK);
        #1;
        alu_ctrl = 6'h21;
        check({tag, "_hi"}, hi_out, exp_hi);
        check({tag, "_lo"}, lo_out, exp_lo);
    endtask

    task automatic br_vec(input string tag, input logic [5:0] opc, input logic [4:0] rt,
                          input logic kill, input logic [31:0] a, input logic [31:0] b, input logic exp);
        instr    = {opc, 5'd3, rt, 16'h1234};
        cmp_kill = kill;
        cmp_a    = a;
        cmp_b    = b;
        #1;
        check(tag, {31'h0, taken}, {31'h0, exp});
    endtask

    initial begin
        RESET = 1'b0;
        op_a = 32'h0; op_b = 32'h0; alu_ctrl = 6'h21; shamt = 5'd0;
        hi_in = 32'h0; lo_in = 32'h0;
        cmp_kill = 1'b0; cmp_a = 32'h0; cmp_b = 32'h0; instr = 32'h0;
        #12;
        check("rst_hi", hi_out, 32'h0);
        check("rst_lo", lo_out, 32'h0);
        @(negedge CLK);
        RESET = 1'b1;

        alu_vec("add_wrap", 6'h20, 32'h7FFF_FFFF, 32'h1,         5'd0, 32'h8000_0000);
        alu_vec("addu",     6'h21, 32'hFFFF_FFFF, 32'h2,         5'd0, 32'h1);
        alu_vec("sub",      6'h22, 32'h5,         32'h7,         5'd0, 32'hFFFF_FFFE);
        alu_vec("slt",      6'h2A, 32'hFFFF_FFFF, 32'h1,         5'd0, 32'h1);
        alu_vec("sltu",     6'h2B, 32'hFFFF_FFFF, 32'h1,         5'd0, 32'h0);
        alu_vec("and",      6'h24, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0, 32'h00F0_000F);
        alu_vec("or",       6'h25, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0, 32'hFFF0_0FFF);
        alu_vec("xor",      6'h26, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0, 32'hFF00_0FF0);
        alu_vec("nor",      6'h27, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0, 32'h000F_F000);
        alu_vec("sra",      6'h03, 32'h0,         32'h8000_0000, 5'd4, 32'hF800_0000);
        alu_vec("srl",      6'h02, 32'h0,         32'h8000_0000, 5'd4, 32'h0800_0000);
        alu_vec("srlv",     6'h06, 32'h24,        32'h8000_0000, 5'd0, 32'h0800_0000);
        alu_vec("srav",     6'h07, 32'h24,        32'h8000_0000, 5'd0, 32'hF800_0000);
        alu_vec("sll31",    6'h00, 32'h0,         32'h1,         5'd31, 32'h8000_0000);
        alu_vec("sllv",     6'h04, 32'h21,        32'h3,         5'd0, 32'h6);
        alu_vec("lui",      6'h0F, 32'h0,         32'h1234_ABCD, 5'd0, 32'hABCD_0000);
        hi_in = 32'hDEAD_BEEF;
        lo_in = 32'h1234_5678;
        alu_vec("mfhi",     6'h10, 32'h0,         32'h0,         5'd0, 32'hDEAD_BEEF);
        alu_vec("mflo",     6'h12, 32'h0,         32'h0,         5'd0, 32'h1234_5678);
        alu_vec("undef",    6'h3F, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'h0);

        muldiv_vec("mult",    6'h18, 32'hFFFF_FFFD, 32'h7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
        @(posedge CLK);
        #1;
        check("hold_hi", hi_out, 32'hFFFF_FFFF);
        check("hold_lo", lo_out, 32'hFFFF_FFEB);
        muldiv_vec("multu",   6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        muldiv_vec("div_neg", 6'h1A, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        muldiv_vec("div_nb",  6'h1A, 32'h7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD);
        muldiv_vec("div_ovf", 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000);
        muldiv_vec("div_z",   6'h1A, 32'hFFFF_FFF7, 32'h0,         32'hFFFF_FFF7, 32'hFFFF_FFFF);
        muldiv_vec("divu",    6'h1B, 32'hFFFF_FFFF, 32'h10,        32'hF,         32'h0FFF_FFFF);
        muldiv_vec("divu_z",  6'h1B, 32'h5,         32'h0,         32'h5,         32'hFFFF_FFFF);

        @(negedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        check("arst_hi", hi_out, 32'h0);
        check("arst_lo", lo_out, 32'h0);

        alu_ctrl = 6'h18;
        op_a     = 32'h1234;
        op_b     = 32'h5678;
        @(posedge CLK);
        #1;
        check("rst_mult_hi", hi_out, 32'h0);
        check("rst_mult_lo", lo_out, 32'h0);
        alu_ctrl = 6'h21;
        @(negedge CLK);
        RESET = 1'b1;

        br_vec("beq_eq",    6'h04, 5'd0, 1'b0, 32'h5,         32'h5, 1'b1);
        br_vec("beq_kill",  6'h04, 5'd0, 1'b1, 32'h5,         32'h5, 1'b0);
        br_vec("beq_ne",    6'h04, 5'd0, 1'b0, 32'h5,         32'h6, 1'b0);
        br_vec("bne",       6'h05, 5'd0, 1'b0, 32'h5,         32'h6, 1'b1);
        br_vec("blez_0",    6'h06, 5'd0, 1'b0, 32'h0,         32'h0, 1'b1);
        br_vec("blez_neg",  6'h06, 5'd0, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1);
        br_vec("blez_pos",  6'h06, 5'd0, 1'b0, 32'h1,         32'h0, 1'b0);
        br_vec("bgtz_0",    6'h07, 5'd0, 1'b0, 32'h0,         32'h0, 1'b0);
        br_vec("bgtz_pos",  6'h07, 5'd0, 1'b0, 32'h1,         32'h0, 1'b1);
        br_vec("bltz",      6'h01, 5'd0, 1'b0, 32'h8000_0000, 32'h0, 1'b1);
        br_vec("bltz_0",    6'h01, 5'd0, 1'b0, 32'h0,         32'h0, 1'b0);
        br_vec("bgez_0",    6'h01, 5'd1, 1'b0, 32'h0,         32'h0, 1'b1);
        br_vec("bgez_kill", 6'h01, 5'd1, 1'b1, 32'h0,         32'h0, 1'b0);
        br_vec("regimm_rt2",6'h01, 5'd2, 1'b0, 32'h0,         32'h0, 1'b0);
        br_vec("op_other",  6'h02, 5'd0, 1'b0, 32'h5,         32'h5, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
